sequenciador_display: RTL

Time-multiplexing sequencer that drives the 2-bit view select of the elevator's 7-segment display manager. It cycles the single digit through floor, movement and occupancy views, with a blank separator between views. It skips the occupancy view when nobody is aboard, and forces the floor view whenever the floor changes. It sits directly upstream of the display manager and feeds its `controle_Mux` input.

---
 rtl/sequenciador_display_if.sv | 22 ++
 rtl/sequenciador_display.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sequenciador_display_if.sv
// Signal bundle between the elevator status sources and the display view sequencer.
// The master drives floor, motion and occupancy inputs; the slave returns the view select.
interface sequenciador_display_if;
  logic [1:0] andar;
  logic       S;
  logic       D;
  logic       P;
  logic       A;
  logic       B;
  logic [1:0] controle_Mux;
  logic       troca;

  modport master (
    output andar, S, D, P, A, B,
    input  controle_Mux, troca
  );

  modport slave (
    input  andar, S, D, P, A, B,
    output controle_Mux, troca
  );
endinterface

// File: rtl/sequenciador_display.sv
// Time-multiplexed view sequencer for the elevator 7-segment display (floor/movement/occupancy).
// Optional movement-view blinking is enabled by defining SEQ_DISPLAY_PISCA_EN.
module sequenciador_display #(
  parameter int unsigned DWELL = 50_000_000,
  parameter int unsigned BLANK = 5_000_000,
  parameter int unsigned BLINK = 6_250_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sequenciador_display_if.slave   bus
);

  localparam int unsigned MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK - 1);

  typedef enum logic [2:0] {
    V_ANDAR,
    B1,
    V_MOV,
    B2,
    V_PES,
    B3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      andar_q;
  logic [1:0]      mux_q, mux_d;
  logic            troca_q, troca_d;
  logic            term;
  logic            floorChg;

`ifdef SEQ_DISPLAY_PISCA_EN
  localparam int unsigned PW = (BLINK > 1) ? $clog2(BLINK) : 1;
  localparam logic [PW-1:0] BLINK_TC = PW'(BLINK - 1);

  logic          phase_q, phase_d;
  logic [PW-1:0] phcnt_q, phcnt_d;
  logic          unused_p;

  assign unused_p = bus.P;
`else
  logic unused_mov;

  assign unused_mov = ^{bus.S, bus.D, bus.P};
`endif

  always_comb begin
    floorChg = (bus.andar != andar_q);

    case (state_q)
      V_ANDAR, V_MOV, V_PES: term = (cnt_q == DWELL_TC);
      default:               term = (cnt_q == BLANK_TC);
    endcase

    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);

    // A floor change wins over both the terminal count and the occupancy skip.
    if (floorChg) begin
      state_d = V_ANDAR;
      cnt_d   = '0;
    end else if (term) begin
      cnt_d = '0;
      case (state_q)
        V_ANDAR: state_d = B1;
        B1:      state_d = V_MOV;
        V_MOV:   state_d = B2;
        B2:      state_d = (bus.A || bus.B) ? V_PES : V_ANDAR;
        V_PES:   state_d = B3;
        B3:      state_d = V_ANDAR;
        default: state_d = V_ANDAR;
      endcase
    end

    // Gating on troca_q keeps the pulse from ever lasting two cycles.
    troca_d = (state_d != state_q) && !troca_q;

`ifdef SEQ_DISPLAY_PISCA_EN
    phase_d = 1'b0;
    phcnt_d = '0;
    if ((state_q == V_MOV) && (state_d == V_MOV) && (bus.S || bus.D)) begin
      if (phcnt_q == BLINK_TC) begin
        phase_d = ~phase_q;
      end else begin
        phase_d = phase_q;
        phcnt_d = phcnt_q + PW'(1);
      end
    end
`endif

    case (state_d)
      V_ANDAR: mux_d = 2'b00;
`ifdef SEQ_DISPLAY_PISCA_EN
      V_MOV:   mux_d = phase_d ? 2'b10 : 2'b01;
`else
      V_MOV:   mux_d = 2'b01;
`endif
      V_PES:   mux_d = 2'b11;
      default: mux_d = 2'b10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= V_ANDAR;
      cnt_q   <= '0;
      andar_q <= 2'b00;
      mux_q   <= 2'b00;
      troca_q <= 1'b0;
`ifdef SEQ_DISPLAY_PISCA_EN
      phase_q <= 1'b0;
      phcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      andar_q <= bus.andar;
      mux_q   <= mux_d;
      troca_q <= troca_d;
`ifdef SEQ_DISPLAY_PISCA_EN
      phase_q <= phase_d;
      phcnt_q <= phcnt_d;
`endif
    end
  end

  assign bus.controle_Mux = mux_q;
  assign bus.troca        = troca_q;

endmodule
